// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default sizing and round-robin pointer arithmetic for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, with wrap. Purely combinational.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW:0]        sum;

  assign dbl = {req, req} >> rr_ptr;
  assign rot = dbl[N_REQ-1:0];

  // Walk downward so the lowest rotated position wins; un-rotate by adding rr_ptr back.
  always_comb begin
    found = 1'b0;
    sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (IW+1)'(k);
      end
    end
    idx = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the FIFO write port: one grant per burst of up to MAX_BURST beats,
// first beat one cycle after arbitration, stalls on fifo_full without losing the grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DW        = DEF_DW,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IW        = $clog2(N_REQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic [DW-1:0] data_arr [N_REQ];
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          cur_valid;
  logic          beat;
  logic          last_beat;
  logic          rel;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    cur_valid = req_valid[grant_id];
    beat      = busy && cur_valid && !fifo_full;
    last_beat = beat && (beat_cnt == CW'(MAX_BURST - 1));
    rel       = busy && (!cur_valid || last_beat);
    fifo_wr   = beat;
    fifo_din  = busy ? data_arr[grant_id] : '0;
    req_ready = '0;
    if (beat) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (beat) beat_cnt <= beat_cnt + CW'(1);
          // A full-stall is neither a beat nor a release, so the grant simply holds.
          if (rel) begin
            rr_ptr <= IW'(rr_next(int'(grant_id), N_REQ));
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: producer queues feed the arbiter, a 16-deep FIFO model sits behind it,
// and a scoreboard of expected (requester, data) beats is checked on every write.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] src_q[N][$];
  logic [7:0] fifo_m[$];
  int         wr_log[$];
  int         offs[$];
  int         cyc, t0, vectors, miscompares;
  logic       rd_req;
  logic       s_wr, s_busy;
  logic [3:0] s_rdy;
  logic [7:0] s_din;
  logic [1:0] s_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic src(input int id, input logic [7:0] d);
    src_q[id].push_back(d);
  endtask

  task automatic expect_beat(input int id, input logic [7:0] d);
    beat_t e;
    e.id = 2'(id);
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // One clock: drive producers and full, sample mid-cycle, then advance the models at the edge.
  task automatic step();
    beat_t e;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = 1'b0;
      req_data[i*DW +: DW] = 8'h00;
      if (src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = src_q[i][0];
      end
    end
    fifo_full = (fifo_m.size() >= 16);
    #4;
    cyc++;
    s_wr = fifo_wr; s_busy = busy; s_rdy = req_ready; s_din = fifo_din; s_gid = grant_id;
    if (s_wr) begin
      wr_log.push_back(cyc);
      chk("wr_while_full", 32'(fifo_full), 0);
      chk("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_id", 32'(s_gid), 32'(e.id));
        chk("beat_data", 32'(s_din), 32'(e.d));
        chk("beat_ready", 32'(s_rdy), 32'(4'b0001 << e.id));
      end
    end else begin
      chk("ready_no_wr", 32'(s_rdy), 0);
    end
    if (!s_busy) chk("din_idle", 32'(s_din), 0);
    @(posedge clk);
    #1;
    if (s_wr) begin
      if (src_q[s_gid].size() > 0) void'(src_q[s_gid].pop_front());
      fifo_m.push_back(s_din);
    end else if (rd_req && fifo_m.size() > 0) begin
      void'(fifo_m.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_nwr"}, 32'(wr_log.size()), 32'(offs.size()));
    for (int k = 0; k < offs.size() && k < wr_log.size(); k++)
      chk({tag, "_cycle"}, 32'(wr_log[k] - t0), 32'(offs[k]));
  endtask

  task automatic begin_test();
    t0 = cyc;
    wr_log.delete();
    offs.delete();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; rd_req = 1'b0;
    fifo_full = 1'b0;
    rst = 1'b1;
    req_valid = '1;
    req_data  = {8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_gid", 32'(grant_id), 0);
    req_valid = '0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Single requester, 6 beats: burst of 4, one idle cycle, then 2.
    begin_test();
    for (int k = 0; k < 6; k++) begin
      src(2, 8'(16 + k));
      expect_beat(2, 8'(16 + k));
    end
    drain("single", 40);
    offs = '{2, 3, 4, 5, 7, 8};
    chk_log("single");
    idle(3);

    // Round robin from rr_ptr=0: requester 0 has two bursts' worth, others one.
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    fifo_m.delete();
    rd_req = 1'b1;
    begin_test();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        src(i, 8'(64 + 16*i + k));
        expect_beat(i, 8'(64 + 16*i + k));
      end
    for (int k = 0; k < 4; k++) begin
      src(0, 8'(68 + k));
      expect_beat(0, 8'(68 + k));
    end
    drain("rr", 60);
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) offs.push_back(2 + 5*b + k);
    chk_log("rr");
    rd_req = 1'b0;
    idle(3);

    // Full back-pressure: 15 entries preloaded, requester 1 sends two beats.
    fifo_m.delete();
    repeat (15) fifo_m.push_back(8'hEE);
    begin_test();
    src(1, 8'hA0); src(1, 8'hA1);
    expect_beat(1, 8'hA0); expect_beat(1, 8'hA1);
    step();
    chk("bp_arb_cycle_wr", 32'(s_wr), 0);
    step();
    chk("bp_first_wr", 32'(s_wr), 1);
    step();
    chk("bp_full_wr", 32'(s_wr), 0);
    chk("bp_full_ready", 32'(s_rdy), 0);
    chk("bp_stall_busy", 32'(s_busy), 1);
    chk("bp_stall_gid", 32'(s_gid), 1);
    step();
    chk("bp_stall2_wr", 32'(s_wr), 0);
    rd_req = 1'b1;
    step();
    chk("bp_pop_cycle_wr", 32'(s_wr), 0);
    rd_req = 1'b0;
    step();
    chk("bp_resume_wr", 32'(s_wr), 1);
    chk("bp_fifo_count", 32'(fifo_m.size()), 16);
    chk("bp_drained", 32'(exp_q.size()), 0);
    offs = '{2, 6};
    chk_log("bp");
    fifo_m.delete();
    idle(3);

    // Early release: requester 3 drops after 2 beats, then 0 and 1 are served in order.
    begin_test();
    src(3, 8'hB0); src(3, 8'hB1); src(0, 8'hC0); src(1, 8'hD0);
    expect_beat(3, 8'hB0); expect_beat(3, 8'hB1);
    expect_beat(0, 8'hC0); expect_beat(1, 8'hD0);
    drain("early", 30);
    offs = '{2, 3, 6, 9};
    chk_log("early");
    idle(3);

    // Requester 3 granted, reset lands mid-burst; afterwards 0 beats 3 from rr_ptr=0.
    begin_test();
    for (int k = 0; k < 4; k++) src(3, 8'(224 + k));
    expect_beat(3, 8'hE0);
    step();
    step();
    chk("mid_first_wr", 32'(s_wr), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr", 32'(fifo_wr), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_din", 32'(fifo_din), 0);
    chk("mid_rst_gid", 32'(grant_id), 0);
    req_valid = '0;
    src_q[3].delete();
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    src(0, 8'hF0); src(3, 8'hF3);
    expect_beat(0, 8'hF0); expect_beat(3, 8'hF3);
    drain("post_rst", 30);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the 16-deep, 8-bit `FIFO` among `N_REQ` independent producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr`/`din` while honouring `full`. It sits directly in front of the FIFO. The FIFO's read side and its `rst` are untouched by this block.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `DW`, 8: data width, must match FIFO `din`
- `MAX_BURST`, 4: maximum beats per grant, ≥1

- `clk` in 1: single clock, all state on posedge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in `N_REQ`: bit i = requester i has a beat
- `req_data` in `N_REQ*DW`: requester i data at `[i*DW +: DW]`
- `req_ready` out `N_REQ`: bit i = beat of requester i accepted this cycle
- `fifo_full` in 1: FIFO `full`
- `fifo_wr` out 1: to FIFO `wr`
- `fifo_din` out `DW`: to FIFO `din`
- `grant_id` out `$clog2(N_REQ)`: currently/last granted requester
- `busy` out 1: grant active

## Operation
- States: `IDLE`, `GRANT`.
- **IDLE.**
  - If any `req_valid`, pick the first set bit searching upward from `rr_ptr` with wrap.
  - Register it into `grant_id`, clear `beat_cnt`, go to `GRANT`.
  - No beat transfers in `IDLE`.
- **GRANT**, with g = `grant_id`:
  - **Beat.** When `req_valid[g] && !fifo_full`, the beat transfers: `req_ready[g]=1`, `fifo_wr=1`, `fifo_din=req_data[g]`, and `beat_cnt` increments.
  - **Stall.** When `req_valid[g] && fifo_full`, the grant is held, no beat transfers, and `beat_cnt` is unchanged. There is no timeout.
  - **Release, burst limit.** The cycle carrying beat number `MAX_BURST` releases the grant.
  - **Release, valid dropped.** Any cycle with `req_valid[g]==0` releases the grant with no beat.
  - **On release.** `rr_ptr <= (g+1) mod N_REQ`, go to `IDLE`.
- **Other outputs.**
  - `req_ready[j]` is 0 for every j≠g, and everywhere in `IDLE`.
  - `fifo_din` is `req_data[grant_id]` whenever `busy`, and 0 in `IDLE`.
  - `fifo_wr` is never asserted while `fifo_full`, so no write is ever dropped by the FIFO.
- **Widths.**
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `rr_ptr` is the same width as `grant_id`.
  - `rr_ptr` wrap is an explicit compare to `N_REQ-1`, not a power-of-two overflow.
- **Mid-operation reset.**
  - Outputs drop immediately, because `rst` is asynchronous.
  - Beats already written remain the FIFO's responsibility.
  - A partially sent burst is not replayed.

## Timing
- **Reset values.** state=`IDLE`, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `busy`=0, `fifo_wr`=0, `req_ready`=0, `fifo_din`=0.
- **Arbitration latency.** `req_valid` rises in cycle N → grant registered at edge N+1 → first beat possible in cycle N+1 (`fifo_wr` high during N+1, FIFO writes at edge N+2).
- **Combinational paths.** `req_ready`, `fifo_wr` and `fifo_din` are combinational from registered state plus `req_valid`, `req_data` and `fifo_full`. There is no path from `req_valid` to state without a register.
- **Release gap.** Release always costs one `IDLE` cycle before the next grant. Peak throughput is `MAX_BURST/(MAX_BURST+1)` beats per cycle.
- **Simultaneous requests.** Resolved purely by `rr_ptr`. Worst-case wait for a continuously valid requester is `(N_REQ-1)*(MAX_BURST+1)` cycles plus full-stall time.
- **FIFO priority.** The FIFO prioritises `wr` over `rd`. Consumers must tolerate reads being blocked during write cycles; this block does not throttle.

## Structure
- Package `fifo_arb_pkg` holds:
  - `arb_state_t` enum {`IDLE`, `GRANT`}.
  - The default-parameter constants.
  - Function `rr_next(ptr, N)` for wrap arithmetic.
- Sub-module `rr_pick`:
  - Combinational, parameterised by `N_REQ`.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: `found` and `idx` (rotate, priority-encode, un-rotate).
- The top holds the state register, counters and output muxing. It instantiates `rr_pick` once.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle → all outputs 0 within the same cycle; `grant_id`=0, `busy`=0.
- **Single requester.** req 2 valid for 6 beats (0x10..0x15), `MAX_BURST`=4, FIFO empty → FIFO receives 0x10..0x13, then one `IDLE` cycle, then 0x14,0x15; `grant_id`=2 throughout.
- **Round-robin rotation.** All 4 valid continuously, 4 beats each → grant order 0,1,2,3,0. No requester gets a second burst before every other valid requester has had one.
- **Full back-pressure.** Preload FIFO with 15 entries; req 1 sends 0xA0,0xA1 → 0xA0 written, then `full`=1 so `fifo_wr`=0 and `req_ready[1]`=0. Pop one entry → 0xA1 written the next cycle. Total entries never exceed 16.
- **Early release.** req 3 drops valid after 2 beats → release in that cycle; `rr_ptr`=0; pending req 0 granted on the following edge.
- **Wrap and rst mid-burst.** req 3 granted, `rst` pulsed after beat 1 → `busy`=0, `rr_ptr`=0; after reset, req 0 and req 3 both valid → req 0 granted first.
